// File: rtl/seq_multiplier_if.sv
// Operand/result bundle between the CPU control/datapath and the sequential multiplier.
interface seq_multiplier_if #(
  parameter int WIDTH = 32
);
  logic [WIDTH-1:0]   A;
  logic [WIDTH-1:0]   B;
  logic               Signed;
  logic               Start;
  logic               Busy;
  logic               Done;
  logic [2*WIDTH-1:0] Product;

  modport master (
    output A, B, Signed, Start,
    input  Busy, Done, Product
  );

  modport slave (
    input  A, B, Signed, Start,
    output Busy, Done, Product
  );
endinterface

// File: rtl/seq_multiplier.sv
// Iterative shift-add multiplier feeding HI/LO; Done is the one-cycle HI/LO load enable.
// Optional SEQ_MULTIPLIER_EARLY_TERM_EN finishes RUN as soon as no multiplier bits remain.
module seq_multiplier #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic            Clock,
  input  logic            Reset,
  seq_multiplier_if.slave bus
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t               state_q, state_d;
  logic [WIDTH-1:0]     mcand_q, mcand_d;
  logic [WIDTH-1:0]     hi_q, hi_d;
  logic [WIDTH-1:0]     lo_q, lo_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 sign_q, sign_d;
  logic [2*WIDTH-1:0]   product_q, product_d;

  logic [WIDTH:0]       sum;
  logic [2*WIDTH-1:0]   shifted;
  logic [2*WIDTH-1:0]   result;
  logic                 last;
  logic                 a_neg, b_neg;
  logic [WIDTH-1:0]     a_mag, b_mag;
  logic                 busy, done;
`ifdef SEQ_MULTIPLIER_EARLY_TERM_EN
  logic [WIDTH-1:0]     remain_mask;
`endif

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q   <= IDLE;
      mcand_q   <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      cnt_q     <= '0;
      sign_q    <= 1'b0;
      product_q <= '0;
    end else begin
      state_q   <= state_d;
      mcand_q   <= mcand_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      cnt_q     <= cnt_d;
      sign_q    <= sign_d;
      product_q <= product_d;
    end
  end

  // One shift-add step; lo_q holds unconsumed multiplier bits below the product bits shifted in.
  always_comb begin
    a_neg   = bus.Signed & bus.A[WIDTH-1];
    b_neg   = bus.Signed & bus.B[WIDTH-1];
    a_mag   = a_neg ? -bus.A : bus.A;
    b_mag   = b_neg ? -bus.B : bus.B;
    sum     = {1'b0, hi_q} + {1'b0, (lo_q[0] ? mcand_q : {WIDTH{1'b0}})};
    shifted = {sum, lo_q[WIDTH-1:1]};
    result  = shifted;
    last    = (cnt_q == CNT_W'(WIDTH-1));
`ifdef SEQ_MULTIPLIER_EARLY_TERM_EN
    remain_mask = ({WIDTH{1'b1}} >> cnt_q) & {{(WIDTH-1){1'b1}}, 1'b0};
    if ((lo_q & remain_mask) == '0) begin
      last   = 1'b1;
      result = shifted >> (CNT_W'(WIDTH-1) - cnt_q);
    end
`endif
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.Start) state_d = RUN;
      RUN:     if (last) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    mcand_d   = mcand_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    cnt_d     = cnt_q;
    sign_d    = sign_q;
    product_d = product_q;
    case (state_q)
      IDLE: begin
        if (bus.Start) begin
          mcand_d = a_mag;
          lo_d    = b_mag;
          hi_d    = '0;
          cnt_d   = '0;
          sign_d  = a_neg ^ b_neg;
        end
      end
      RUN: begin
        hi_d  = shifted[2*WIDTH-1:WIDTH];
        lo_d  = shifted[WIDTH-1:0];
        cnt_d = cnt_q + 1'b1;
        if (last) product_d = sign_q ? -result : result;
      end
      default: ;
    endcase
  end

  always_comb begin
    busy = (state_q == RUN);
    done = (state_q == DONE);
  end

  assign bus.Busy    = busy;
  assign bus.Done    = done;
  assign bus.Product = product_q;

endmodule

// File: tb/tb_seq_multiplier.sv
// Directed-vector bench for seq_multiplier; checks timing of Busy/Done and Product values.
module tb_seq_multiplier;

  logic Clock;
  logic Reset;
  int   compared;
  int   mismatched;
  logic [63:0] prev_product;

  seq_multiplier_if #(.WIDTH(32)) mif ();

  seq_multiplier #(.WIDTH(32), .CNT_W(6)) dut (
    .Clock (Clock),
    .Reset (Reset),
    .bus   (mif.slave)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic int done_cycle(input logic [31:0] b, input logic s);
    logic [31:0] mag;
    int hi;
    mag = (s && b[31]) ? (32'd0 - b) : b;
    hi = 0;
    for (int i = 0; i < 32; i++) if (mag[i]) hi = i;
`ifdef SEQ_MULTIPLIER_EARLY_TERM_EN
    return hi + 2;
`else
    return 33;
`endif
  endfunction

  // Start one op; optionally raise a second Start in cycle 10 that must be ignored.
  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic s,
                        input logic [63:0] exp, input bit inject);
    int lat;
    lat = done_cycle(b, s);
    mif.A = a; mif.B = b; mif.Signed = s; mif.Start = 1'b1;
    tick();
    mif.Start = 1'b0;
    mif.A = $urandom; mif.B = $urandom; mif.Signed = 1'b0;
    for (int c = 1; c <= lat + 3; c++) begin
      chk($sformatf("busy_c%0d", c), {63'd0, mif.Busy}, {63'd0, c < lat});
      chk($sformatf("done_c%0d", c), {63'd0, mif.Done}, {63'd0, c == lat});
      chk($sformatf("product_c%0d", c), mif.Product, (c < lat) ? prev_product : exp);
      if (inject && c == 10) begin
        mif.A = 32'd2; mif.B = 32'd2; mif.Start = 1'b1;
      end
      if (inject && c == 11) mif.Start = 1'b0;
      tick();
    end
    $display("op a=%h b=%h signed=%0d done_cycle=%0d product=%h expected=%h",
             a, b, s, lat, mif.Product, exp);
    prev_product = exp;
  endtask

  initial begin
    compared = 0;
    mismatched = 0;
    prev_product = 64'd0;
    mif.A = '0; mif.B = '0; mif.Signed = 1'b0; mif.Start = 1'b0;
    Reset = 1'b1;
    tick();
    tick();
    Reset = 1'b0;

    for (int c = 0; c < 5; c++) begin
      chk("idle_product", mif.Product, 64'd0);
      chk("idle_busy", {63'd0, mif.Busy}, 64'd0);
      chk("idle_done", {63'd0, mif.Done}, 64'd0);
      tick();
    end
    $display("reset idle product=%h busy=%0d done=%0d", mif.Product, mif.Busy, mif.Done);

    run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 64'hFFFF_FFFE_0000_0001, 1'b0);
    run_op(32'hFFFF_FFFD, 32'h0000_0007, 1'b1, 64'hFFFF_FFFF_FFFF_FFEB, 1'b0);
    run_op(32'h8000_0000, 32'h8000_0000, 1'b1, 64'h4000_0000_0000_0000, 1'b0);
    run_op(32'h0000_0003, 32'h8000_0001, 1'b0, 64'h0000_0001_8000_0003, 1'b1);
    run_op(32'h0000_0007, 32'hFFFF_FFFE, 1'b1, 64'hFFFF_FFFF_FFFF_FFF2, 1'b0);

    // Abort an operation with Reset in cycle 15 of RUN
    mif.A = 32'h1234_5678; mif.B = 32'hF000_0000; mif.Signed = 1'b0; mif.Start = 1'b1;
    tick();
    mif.Start = 1'b0;
    for (int c = 1; c < 15; c++) tick();
    chk("pre_reset_busy", {63'd0, mif.Busy}, 64'd1);
    Reset = 1'b1;
    mif.Start = 1'b1;
    tick();
    Reset = 1'b0;
    mif.Start = 1'b0;
    chk("abort_busy", {63'd0, mif.Busy}, 64'd0);
    chk("abort_product", mif.Product, 64'd0);
    chk("abort_done", {63'd0, mif.Done}, 64'd0);
    for (int c = 0; c < 40; c++) begin
      chk("abort_no_done", {63'd0, mif.Done}, 64'd0);
      tick();
    end
    $display("reset mid-op busy=%0d product=%h", mif.Busy, mif.Product);
    prev_product = 64'd0;

    run_op(32'd6, 32'd7, 1'b0, 64'h0000_0000_0000_002A, 1'b0);
    run_op(32'd5, 32'd1, 1'b0, 64'h0000_0000_0000_0005, 1'b0);
    run_op(32'd5, 32'd0, 1'b0, 64'h0000_0000_0000_0000, 1'b0);
    run_op(32'd1, 32'h8000_0000, 1'b0, 64'h0000_0000_8000_0000, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
